control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Multi-cycle, parametrised successor to the single-cycle combinational control logic unit.
- Accepts a full 32-bit RV32I instruction over a valid/ready handshake and decodes all base opcodes, including SLT/SLTU and I-type shifts.
- Sequences each instruction through DECODE, EXEC, MEM_WAIT and WB states, with registered control outputs and a bounded memory-acknowledge wait.
- Sits between instruction fetch and the datapath (ALU, register file, data memory).

Parameters:
MEM_TIMEOUT, 15, maximum cycles spent in MEM_WAIT without mem_ack before a fault; counter width is $clog2(MEM_TIMEOUT+1).
EN_SLT, 1, when 1, SLT/SLTU/SLTI/SLTIU decode to FOP_SLT/FOP_SLTU; when 0 they are illegal.

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  synchronous active-low reset
inst_valid  input  1  instruction presented
inst_ready  output  1  sequencer can accept an instruction
instruction  input  32  RV32I instruction word
mem_ack  input  1  data memory completed the request
alu_op  output  4  fop_t operation
branch_type  output  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 unconditional jump
reg_write_en, alu_mux_en, store_byte, load_byte, mem_to_reg, pc_absolute_jump_vec, read_next_pc, write_mem, read_mem  output  1 each  datapath controls
done  output  1  one-cycle pulse, instruction retired
illegal_inst  output  1  one-cycle pulse, undecodable instruction
mem_fault  output  1  one-cycle pulse, mem_ack timeout

Behaviour:
- Reset: nrst low at a clock edge puts the FSM in IDLE, clears the latched instruction and the wait counter, and drives every output to 0 except inst_ready=1. Reset overrides any state, including MEM_WAIT mid-request.
- All control outputs are registered. They are 0 in IDLE and DECODE and are non-zero only in EXEC, MEM_WAIT and WB.
- States are IDLE, DECODE, EXEC, MEM_WAIT, WB.
- IDLE:
  - inst_ready=1.
  - On inst_valid&&inst_ready, latch instruction and go to DECODE.
  - inst_ready is 0 in every other state.
  - Instruction bits are ignored unless inst_valid=1.
- DECODE (one cycle):
  - Decode on opcode[6:0], funct3 and funct7[5].
  - Illegal instruction: pulse illegal_inst on the next cycle and return to IDLE; all controls stay 0.
  - LOAD (0000011) or STORE (0100011): go to MEM_WAIT.
  - All other legal opcodes: go to EXEC.
- EXEC (one cycle): assert the decoded controls for one cycle, pulse done in the same cycle, then go to IDLE.
  - R-type (0110011): alu_mux_en=0, reg_write_en=1.
  - I-ALU (0010011): alu_mux_en=1, reg_write_en=1. SRAI is selected by funct7[5].
  - BRANCH (1100011): branch_type per funct3, alu_op=FOP_SUB, reg_write_en=0. funct3 010 and 011 are illegal.
  - JAL (1101111): branch_type=7, read_next_pc=1, reg_write_en=1.
  - JALR (1100111): same as JAL plus pc_absolute_jump_vec=1 and alu_mux_en=1.
  - LUI (0110111): alu_op=FOP_IMM, alu_mux_en=1, reg_write_en=1.
  - AUIPC (0010111): alu_op=FOP_ADD, alu_mux_en=1, reg_write_en=1.
- MEM_WAIT:
  - alu_op=FOP_ADD and alu_mux_en=1 throughout.
  - read_mem=1 (load) or write_mem=1 (store) is held until mem_ack.
  - load_byte / store_byte = (funct3==000). Only funct3 000 and 010 are legal; any other funct3 is illegal in DECODE.
  - Counter increments each cycle without mem_ack.
  - mem_ack on a store: pulse done, go to IDLE.
  - mem_ack on a load: go to WB.
  - Counter reaches MEM_TIMEOUT with no mem_ack: deassert all controls, pulse mem_fault, go to IDLE.
  - mem_ack in the same cycle the counter hits the limit counts as acknowledged.
- WB (one cycle): mem_to_reg=1, reg_write_en=1, load_byte held, done pulses. Then go to IDLE.
- Latency from the accept edge at cycle N:
  - ALU/branch/jump: done at N+2, inst_ready at N+3.
  - Load with mem_ack at the first MEM_WAIT cycle: done at N+3.
  - Store with the same timing: done at N+2.
- mem_ack outside MEM_WAIT is ignored.

Decomposition:
- Package control_pkg holds:
  - inst_type enum;
  - fop_t, extended with FOP_SLT=9 and FOP_SLTU=10;
  - opcode localparams;
  - branch_type localparams;
  - seq_state_t enum.
- Sub-module control_decoder is purely combinational. It maps instruction[31:0] to a control bundle plus an illegal flag, and the FSM registers its outputs.

Test Plan:
1. ADD 0x002081B3 accepted at cycle 0 → cycle 2: alu_op=0, reg_write_en=1, alu_mux_en=0, done=1; cycle 3: inst_ready=1.
2. LB 0x00008183 with mem_ack at the 3rd MEM_WAIT cycle → read_mem=1 and load_byte=1 for 3 cycles; next cycle WB: mem_to_reg=1, reg_write_en=1, done=1.
3. SW 0x0020A023 with MEM_TIMEOUT=4 and mem_ack never asserted → write_mem=1 for 4 cycles, then mem_fault=1 for one cycle with all controls 0, then IDLE.
4. BLTU 0x0020E463 → EXEC: branch_type=5, alu_op=FOP_SUB, reg_write_en=0. JALR 0x000080E7 → branch_type=7, pc_absolute_jump_vec=1, read_next_pc=1.
5. Illegal opcode 0x0000007F, and SLT 0x0020A1B3 with EN_SLT=0 → illegal_inst pulses for one cycle, no done, IDLE next cycle.
6. nrst driven low during MEM_WAIT of a load → next edge: read_mem=0, inst_ready=1, no done/mem_fault. A following ADD completes normally.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
// Shared types and constants for the RV32I control sequencer:
//   fop_t        - ALU operation code driven on alu_op
//   inst_type_t  - instruction class produced by the decoder
//   OPC_*        - base opcode values (instruction[6:0])
//   BR_*         - branch_type encodings
//   seq_state_t  - sequencer FSM states
//   ctrl_t       - bundle of datapath control outputs
//   alu_fop()    - maps funct3 plus the alternate bit to an ALU operation
// -----------------------------------------------------------------------------
package control_pkg;

  typedef enum logic [3:0] {
    FOP_ADD  = 4'd0,
    FOP_SUB  = 4'd1,
    FOP_AND  = 4'd2,
    FOP_OR   = 4'd3,
    FOP_XOR  = 4'd4,
    FOP_SLL  = 4'd5,
    FOP_SRL  = 4'd6,
    FOP_SRA  = 4'd7,
    FOP_IMM  = 4'd8,
    FOP_SLT  = 4'd9,
    FOP_SLTU = 4'd10
  } fop_t;

  typedef enum logic [3:0] {
    IT_R,
    IT_I_ALU,
    IT_LOAD,
    IT_STORE,
    IT_BRANCH,
    IT_JAL,
    IT_JALR,
    IT_LUI,
    IT_AUIPC,
    IT_ILLEGAL
  } inst_type_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;
  localparam logic [2:0] BR_JUMP = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM_WAIT,
    S_WB
  } seq_state_t;

  typedef struct packed {
    fop_t       alu_op;
    logic [2:0] branch_type;
    logic       reg_write_en;
    logic       alu_mux_en;
    logic       store_byte;
    logic       load_byte;
    logic       mem_to_reg;
    logic       pc_absolute_jump_vec;
    logic       read_next_pc;
    logic       write_mem;
    logic       read_mem;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = ctrl_t'(16'h0000);

  // alt selects SUB over ADD and SRA over SRL.
  function automatic fop_t alu_fop(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? FOP_SUB : FOP_ADD;
      3'b001:  return FOP_SLL;
      3'b010:  return FOP_SLT;
      3'b011:  return FOP_SLTU;
      3'b100:  return FOP_XOR;
      3'b101:  return alt ? FOP_SRA : FOP_SRL;
      3'b110:  return FOP_OR;
      default: return FOP_AND;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// -----------------------------------------------------------------------------
// control_sequencer_if
// Bundles the instruction handshake, memory acknowledge and all datapath
// control outputs of the sequencer.
//   slave  modport: the sequencer (consumes inst_valid/instruction/mem_ack,
//                   drives inst_ready, controls and status pulses)
//   master modport: fetch/datapath side (the mirror image)
// -----------------------------------------------------------------------------
interface control_sequencer_if;
  import control_pkg::*;

  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic        mem_ack;
  fop_t        alu_op;
  logic [2:0]  branch_type;
  logic        reg_write_en;
  logic        alu_mux_en;
  logic        store_byte;
  logic        load_byte;
  logic        mem_to_reg;
  logic        pc_absolute_jump_vec;
  logic        read_next_pc;
  logic        write_mem;
  logic        read_mem;
  logic        done;
  logic        illegal_inst;
  logic        mem_fault;

  modport slave (
    input  inst_valid, instruction, mem_ack,
    output inst_ready, alu_op, branch_type, reg_write_en, alu_mux_en,
           store_byte, load_byte, mem_to_reg, pc_absolute_jump_vec,
           read_next_pc, write_mem, read_mem, done, illegal_inst, mem_fault
  );

  modport master (
    output inst_valid, instruction, mem_ack,
    input  inst_ready, alu_op, branch_type, reg_write_en, alu_mux_en,
           store_byte, load_byte, mem_to_reg, pc_absolute_jump_vec,
           read_next_pc, write_mem, read_mem, done, illegal_inst, mem_fault
  );

endinterface

// File: rtl/control_sequencer_decoder.sv
// -----------------------------------------------------------------------------
// control_decoder
// Purely combinational RV32I decoder. Classifies the instruction and produces
// the control bundle used in EXEC (ALU/branch/jump) or MEM_WAIT (load/store).
// Ports:
//   instruction [31:0] in  - latched instruction word
//   ctrl               out - control bundle (all zero when illegal)
//   itype              out - instruction class
//   illegal            out - undecodable instruction
// Parameter EN_SLT: 0 makes SLT/SLTU/SLTI/SLTIU illegal.
// -----------------------------------------------------------------------------
module control_decoder
  import control_pkg::*;
#(
  parameter int EN_SLT = 1
) (
  input  logic [31:0] instruction,
  output ctrl_t       ctrl,
  output inst_type_t  itype,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       slt_blocked;
  logic       unused_fields;

  assign opcode        = instruction[6:0];
  assign funct3        = instruction[14:12];
  assign f7b5          = instruction[30];
  assign slt_blocked   = (EN_SLT == 0) && ((funct3 == 3'b010) || (funct3 == 3'b011));
  // Register and immediate fields are the datapath's business.
  assign unused_fields = ^{instruction[31], instruction[29:15], instruction[11:7]};

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    ctrl  = CTRL_NONE;
    itype = IT_ILLEGAL;
    case (opcode)
      OPC_OP: begin
        ctrl.alu_op       = alu_fop(funct3, f7b5);
        ctrl.reg_write_en = 1'b1;
        if (!slt_blocked) itype = IT_R;
      end
      OPC_OP_IMM: begin
        // Bit 30 is immediate data except for SRLI/SRAI.
        ctrl.alu_op       = alu_fop(funct3, f7b5 && (funct3 == 3'b101));
        ctrl.alu_mux_en   = 1'b1;
        ctrl.reg_write_en = 1'b1;
        if (!slt_blocked) itype = IT_I_ALU;
      end
      OPC_BRANCH: begin
        ctrl.alu_op = FOP_SUB;
        itype       = IT_BRANCH;
        case (funct3)
          3'b000:  ctrl.branch_type = BR_BEQ;
          3'b001:  ctrl.branch_type = BR_BNE;
          3'b100:  ctrl.branch_type = BR_BLT;
          3'b101:  ctrl.branch_type = BR_BGE;
          3'b110:  ctrl.branch_type = BR_BLTU;
          3'b111:  ctrl.branch_type = BR_BGEU;
          default: begin
            ctrl.branch_type = BR_NONE;
            itype            = IT_ILLEGAL;
          end
        endcase
      end
      OPC_JAL: begin
        ctrl.branch_type  = BR_JUMP;
        ctrl.read_next_pc = 1'b1;
        ctrl.reg_write_en = 1'b1;
        itype             = IT_JAL;
      end
      OPC_JALR: begin
        ctrl.branch_type          = BR_JUMP;
        ctrl.read_next_pc         = 1'b1;
        ctrl.reg_write_en         = 1'b1;
        ctrl.pc_absolute_jump_vec = 1'b1;
        ctrl.alu_mux_en           = 1'b1;
        itype                     = IT_JALR;
      end
      OPC_LUI: begin
        ctrl.alu_op       = FOP_IMM;
        ctrl.alu_mux_en   = 1'b1;
        ctrl.reg_write_en = 1'b1;
        itype             = IT_LUI;
      end
      OPC_AUIPC: begin
        ctrl.alu_op       = FOP_ADD;
        ctrl.alu_mux_en   = 1'b1;
        ctrl.reg_write_en = 1'b1;
        itype             = IT_AUIPC;
      end
      OPC_LOAD, OPC_STORE: begin
        // Address = rs1 + immediate for both directions.
        ctrl.alu_op     = FOP_ADD;
        ctrl.alu_mux_en = 1'b1;
        if (opcode == OPC_LOAD) begin
          ctrl.read_mem  = 1'b1;
          ctrl.load_byte = (funct3 == 3'b000);
        end else begin
          ctrl.write_mem  = 1'b1;
          ctrl.store_byte = (funct3 == 3'b000);
        end
        // Only byte and word accesses are supported.
        if ((funct3 == 3'b000) || (funct3 == 3'b010)) begin
          if (opcode == OPC_LOAD) itype = IT_LOAD;
          else                    itype = IT_STORE;
        end
      end
      default: ;
    endcase
    if (itype == IT_ILLEGAL) ctrl = CTRL_NONE;
  end

  assign illegal = (itype == IT_ILLEGAL);

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Multi-cycle RV32I control sequencer: accepts an instruction over a
// valid/ready handshake and steps it through DECODE, EXEC, MEM_WAIT and WB,
// driving registered datapath controls.
// Ports:
//   clk   in - system clock, rising edge
//   nrst  in - synchronous active-low reset
//   bus      - control_sequencer_if.slave: inst_valid/inst_ready/instruction,
//              mem_ack, datapath controls, done/illegal_inst/mem_fault pulses
// Parameters:
//   MEM_TIMEOUT - MEM_WAIT cycles without mem_ack before mem_fault (>= 1)
//   EN_SLT      - 0 makes the set-less-than family illegal
// -----------------------------------------------------------------------------
module control_sequencer
  import control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int EN_SLT      = 1
) (
  input logic                clk,
  input logic                nrst,
  control_sequencer_if.slave bus
);

  localparam int              CNT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

  seq_state_t       state_q;
  logic [31:0]      inst_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  ctrl_t            ctrl_q;
  ctrl_t            wb_ctrl;
  logic             inst_ready_q;
  logic             done_q;
  logic             illegal_q;
  logic             fault_q;
  logic             store_ack;

  ctrl_t            dec_ctrl;
  inst_type_t       dec_type;
  logic             dec_illegal;

  control_decoder #(.EN_SLT(EN_SLT)) u_decoder (
    .instruction (inst_q),
    .ctrl        (dec_ctrl),
    .itype       (dec_type),
    .illegal     (dec_illegal)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    wb_ctrl              = CTRL_NONE;
    wb_ctrl.mem_to_reg   = 1'b1;
    wb_ctrl.reg_write_en = 1'b1;
    wb_ctrl.load_byte    = ctrl_q.load_byte;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
    if (!nrst) begin
      state_q      <= S_IDLE;
      inst_q       <= '0;
      cnt_q        <= '0;
      ctrl_q       <= CTRL_NONE;
      inst_ready_q <= 1'b1;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.inst_valid && inst_ready_q) begin
            inst_q       <= bus.instruction;
            inst_ready_q <= 1'b0;
            state_q      <= S_DECODE;
          end
        end
        S_DECODE: begin
          cnt_q <= '0;
          if (dec_illegal) begin
            illegal_q    <= 1'b1;
            inst_ready_q <= 1'b1;
            state_q      <= S_IDLE;
          end else if ((dec_type == IT_LOAD) || (dec_type == IT_STORE)) begin
            ctrl_q  <= dec_ctrl;
            state_q <= S_MEM_WAIT;
          end else begin
            ctrl_q  <= dec_ctrl;
            done_q  <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC, S_WB: begin
          ctrl_q       <= CTRL_NONE;
          inst_ready_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        S_MEM_WAIT: begin
          // An acknowledge in the last allowed cycle wins over the timeout.
          if (bus.mem_ack) begin
            if (dec_type == IT_LOAD) begin
              ctrl_q  <= wb_ctrl;
              done_q  <= 1'b1;
              state_q <= S_WB;
            end else begin
              ctrl_q       <= CTRL_NONE;
              inst_ready_q <= 1'b1;
              state_q      <= S_IDLE;
            end
          end else if (cnt_inc == CNT_LIMIT) begin
            ctrl_q       <= CTRL_NONE;
            fault_q      <= 1'b1;
            inst_ready_q <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          ctrl_q       <= CTRL_NONE;
          inst_ready_q <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  // A store retires in the cycle its acknowledge arrives, two cycles after
  // accept; this is the only done source not taken straight from a register.
  assign store_ack = (state_q == S_MEM_WAIT) && (dec_type == IT_STORE) && bus.mem_ack;

  assign bus.inst_ready           = inst_ready_q;
  assign bus.alu_op               = ctrl_q.alu_op;
  assign bus.branch_type          = ctrl_q.branch_type;
  assign bus.reg_write_en         = ctrl_q.reg_write_en;
  assign bus.alu_mux_en           = ctrl_q.alu_mux_en;
  assign bus.store_byte           = ctrl_q.store_byte;
  assign bus.load_byte            = ctrl_q.load_byte;
  assign bus.mem_to_reg           = ctrl_q.mem_to_reg;
  assign bus.pc_absolute_jump_vec = ctrl_q.pc_absolute_jump_vec;
  assign bus.read_next_pc         = ctrl_q.read_next_pc;
  assign bus.write_mem            = ctrl_q.write_mem;
  assign bus.read_mem             = ctrl_q.read_mem;
  assign bus.done                 = done_q | store_ack;
  assign bus.illegal_inst         = illegal_q;
  assign bus.mem_fault            = fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Self-checking bench. dut0 uses MEM_TIMEOUT=4, EN_SLT=0; dut1 uses the
// defaults and exercises the set-less-than decode. Inputs change and outputs
// are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  control_sequencer_if bus0 ();
  control_sequencer_if bus1 ();

  control_sequencer #(.MEM_TIMEOUT(4), .EN_SLT(0)) dut0 (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus0)
  );

  control_sequencer dut1 (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus1)
  );

  // Observed outputs: ready, alu_op, branch_type, 9 controls, 3 pulses.
  typedef struct packed {
    logic       inst_ready;
    logic [3:0] alu_op;
    logic [2:0] branch_type;
    logic [8:0] ctl;
    logic [2:0] pulses;
  } obs_t;

  typedef struct {
    string       name;
    logic [31:0] inst;
    obs_t        exp;
  } vec_t;

  // ctl bits: reg_write_en, alu_mux_en, store_byte, load_byte, mem_to_reg,
  //           pc_absolute_jump_vec, read_next_pc, write_mem, read_mem
  localparam logic [8:0] C_RWE  = 9'h100;
  localparam logic [8:0] C_MUX  = 9'h080;
  localparam logic [8:0] C_SB   = 9'h040;
  localparam logic [8:0] C_LB   = 9'h020;
  localparam logic [8:0] C_M2R  = 9'h010;
  localparam logic [8:0] C_PCA  = 9'h008;
  localparam logic [8:0] C_RNPC = 9'h004;
  localparam logic [8:0] C_WM   = 9'h002;
  localparam logic [8:0] C_RM   = 9'h001;
  localparam logic [2:0] P_DONE = 3'b100;
  localparam logic [2:0] P_ILL  = 3'b010;
  localparam logic [2:0] P_FLT  = 3'b001;
  localparam int         NV     = 20;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[NV];

  function automatic obs_t ob(input logic rdy, input logic [3:0] op, input logic [2:0] br,
                              input logic [8:0] ctl, input logic [2:0] pls);
    obs_t o;
    o = {rdy, op, br, ctl, pls};
    return o;
  endfunction

  function automatic obs_t ex(input logic [3:0] op, input logic [2:0] br, input logic [8:0] ctl);
    return ob(1'b0, op, br, ctl, P_DONE);
  endfunction

  function automatic obs_t idle_o();
    return ob(1'b1, 4'd0, 3'd0, 9'd0, 3'd0);
  endfunction

  function automatic obs_t wait_o(input logic [8:0] ctl);
    return ob(1'b0, 4'd0, 3'd0, ctl, 3'd0);
  endfunction

  function automatic obs_t obs0();
    obs_t o;
    o = {bus0.inst_ready, bus0.alu_op, bus0.branch_type,
         bus0.reg_write_en, bus0.alu_mux_en, bus0.store_byte, bus0.load_byte,
         bus0.mem_to_reg, bus0.pc_absolute_jump_vec, bus0.read_next_pc,
         bus0.write_mem, bus0.read_mem, bus0.done, bus0.illegal_inst, bus0.mem_fault};
    return o;
  endfunction

  function automatic obs_t obs1();
    obs_t o;
    o = {bus1.inst_ready, bus1.alu_op, bus1.branch_type,
         bus1.reg_write_en, bus1.alu_mux_en, bus1.store_byte, bus1.load_byte,
         bus1.mem_to_reg, bus1.pc_absolute_jump_vec, bus1.read_next_pc,
         bus1.write_mem, bus1.read_mem, bus1.done, bus1.illegal_inst, bus1.mem_fault};
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (rdy|op|br|ctl|done,ill,flt)", name, act, exp);
    end
  endtask

  // Present an instruction at the current falling edge; returns in DECODE.
  task automatic accept0(input string name, input logic [31:0] inst);
    bus0.inst_valid  = 1'b1;
    bus0.instruction = inst;
    check({name, "/idle"}, obs0(), idle_o());
    @(negedge clk);
    bus0.inst_valid  = 1'b0;
    bus0.instruction = 32'hFFFF_FFFF;
    check({name, "/decode"}, obs0(), '0);
  endtask

  task automatic run0(input string name, input logic [31:0] inst, input obs_t exp);
    accept0(name, inst);
    @(negedge clk);
    check({name, "/exec"}, obs0(), exp);
    @(negedge clk);
    check({name, "/after"}, obs0(), idle_o());
  endtask

  task automatic run1(input string name, input logic [31:0] inst, input obs_t exp);
    bus1.inst_valid  = 1'b1;
    bus1.instruction = inst;
    @(negedge clk);
    bus1.inst_valid  = 1'b0;
    bus1.instruction = 32'h0;
    check({name, "/decode"}, obs1(), '0);
    @(negedge clk);
    check({name, "/exec"}, obs1(), exp);
    @(negedge clk);
    check({name, "/after"}, obs1(), idle_o());
  endtask

  initial begin
    nrst             = 1'b0;
    bus0.inst_valid  = 1'b0;
    bus0.instruction = 32'h0;
    bus0.mem_ack     = 1'b0;
    bus1.inst_valid  = 1'b0;
    bus1.instruction = 32'h0;
    bus1.mem_ack     = 1'b0;

    vecs[0]  = '{"add",    32'h002081B3, ex(4'd0,  3'd0, C_RWE)};
    vecs[1]  = '{"sub",    32'h402081B3, ex(4'd1,  3'd0, C_RWE)};
    vecs[2]  = '{"sra",    32'h4020D1B3, ex(4'd7,  3'd0, C_RWE)};
    vecs[3]  = '{"and",    32'h0020F1B3, ex(4'd2,  3'd0, C_RWE)};
    vecs[4]  = '{"srai",   32'h4030D093, ex(4'd7,  3'd0, C_RWE | C_MUX)};
    vecs[5]  = '{"addi30", 32'h40008093, ex(4'd0,  3'd0, C_RWE | C_MUX)};
    vecs[6]  = '{"xori",   32'h0010C093, ex(4'd4,  3'd0, C_RWE | C_MUX)};
    vecs[7]  = '{"bltu",   32'h0020E463, ex(4'd1,  3'd5, 9'd0)};
    vecs[8]  = '{"beq",    32'h00208463, ex(4'd1,  3'd1, 9'd0)};
    vecs[9]  = '{"bgeu",   32'h0020F463, ex(4'd1,  3'd6, 9'd0)};
    vecs[10] = '{"jal",    32'h008000EF, ex(4'd0,  3'd7, C_RWE | C_RNPC)};
    vecs[11] = '{"jalr",   32'h000080E7, ex(4'd0,  3'd7, C_RWE | C_MUX | C_PCA | C_RNPC)};
    vecs[12] = '{"lui",    32'h123450B7, ex(4'd8,  3'd0, C_RWE | C_MUX)};
    vecs[13] = '{"auipc",  32'h00001097, ex(4'd0,  3'd0, C_RWE | C_MUX)};
    vecs[14] = '{"ill_op", 32'h0000007F, ob(1'b1, 4'd0, 3'd0, 9'd0, P_ILL)};
    vecs[15] = '{"slt_off",32'h0020A1B3, ob(1'b1, 4'd0, 3'd0, 9'd0, P_ILL)};
    vecs[16] = '{"sltiu_off",32'h0010B093, ob(1'b1, 4'd0, 3'd0, 9'd0, P_ILL)};
    vecs[17] = '{"br_f3_2",32'h0020A463, ob(1'b1, 4'd0, 3'd0, 9'd0, P_ILL)};
    vecs[18] = '{"lh",     32'h00009183, ob(1'b1, 4'd0, 3'd0, 9'd0, P_ILL)};
    vecs[19] = '{"st_f3_4",32'h0020C023, ob(1'b1, 4'd0, 3'd0, 9'd0, P_ILL)};

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset/dut0", obs0(), idle_o());
    check("reset/dut1", obs1(), idle_o());
    nrst = 1'b1;
    @(negedge clk);

    // Single-cycle instructions and illegal decodes.
    for (int i = 0; i < NV; i++) run0(vecs[i].name, vecs[i].inst, vecs[i].exp);

    // Set-less-than family with EN_SLT=1.
    run1("slt_on",   32'h0020A1B3, ex(4'd9,  3'd0, C_RWE));
    run1("sltiu_on", 32'h0010B093, ex(4'd10, 3'd0, C_RWE | C_MUX));

    // LB: mem_ack during DECODE is ignored, real ack in the 3rd wait cycle.
    accept0("lb", 32'h00008183);
    bus0.mem_ack = 1'b1;
    @(negedge clk);
    bus0.mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("lb/wait", obs0(), wait_o(C_MUX | C_LB | C_RM));
      if (c == 2) bus0.mem_ack = 1'b1;
      @(negedge clk);
    end
    bus0.mem_ack = 1'b0;
    check("lb/wb", obs0(), ob(1'b0, 4'd0, 3'd0, C_RWE | C_M2R | C_LB, P_DONE));
    @(negedge clk);
    check("lb/after", obs0(), idle_o());

    // LW acknowledged in the first wait cycle: done three cycles after accept.
    accept0("lw", 32'h0000A183);
    @(negedge clk);
    check("lw/wait", obs0(), wait_o(C_MUX | C_RM));
    bus0.mem_ack = 1'b1;
    @(negedge clk);
    bus0.mem_ack = 1'b0;
    check("lw/wb", obs0(), ob(1'b0, 4'd0, 3'd0, C_RWE | C_M2R, P_DONE));
    @(negedge clk);
    check("lw/after", obs0(), idle_o());

    // SB acknowledged in the first wait cycle: done two cycles after accept.
    accept0("sb", 32'h00208023);
    @(negedge clk);
    check("sb/wait", obs0(), wait_o(C_MUX | C_SB | C_WM));
    bus0.mem_ack = 1'b1;
    #1;
    check("sb/done", obs0(), ob(1'b0, 4'd0, 3'd0, C_MUX | C_SB | C_WM, P_DONE));
    @(negedge clk);
    bus0.mem_ack = 1'b0;
    check("sb/after", obs0(), idle_o());

    // SW never acknowledged: four write cycles then mem_fault.
    accept0("sw_to", 32'h0020A023);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("sw_to/wait", obs0(), wait_o(C_MUX | C_WM));
    end
    @(negedge clk);
    check("sw_to/fault", obs0(), ob(1'b1, 4'd0, 3'd0, 9'd0, P_FLT));
    @(negedge clk);
    check("sw_to/after", obs0(), idle_o());

    // SW acknowledged in the last allowed cycle: retires, no fault.
    accept0("sw_last", 32'h0020A023);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("sw_last/wait", obs0(), wait_o(C_MUX | C_WM));
    end
    bus0.mem_ack = 1'b1;
    #1;
    check("sw_last/done", obs0(), ob(1'b0, 4'd0, 3'd0, C_MUX | C_WM, P_DONE));
    @(negedge clk);
    bus0.mem_ack = 1'b0;
    check("sw_last/after", obs0(), idle_o());

    // Reset in the middle of a load wait.
    accept0("lb_rst", 32'h00008183);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("lb_rst/wait", obs0(), wait_o(C_MUX | C_LB | C_RM));
    end
    nrst = 1'b0;
    @(negedge clk);
    check("lb_rst/reset", obs0(), idle_o());
    nrst = 1'b1;
    @(negedge clk);
    check("lb_rst/quiet", obs0(), idle_o());
    run0("add_post_rst", 32'h002081B3, ex(4'd0, 3'd0, C_RWE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
